// File: rtl/pcie_bench_app.sv
`timescale 1ns/1ps
// pcie_bench_app: FPGA-side responder for the PCIe round-trip latency
// benchmark. A timer write starts a run, one F2C chunk is emitted, and the
// cycle count until the host's response is frozen for readback.
module pcie_bench_app #(
  parameter int TIMER_CHAN    = 0,
  parameter int SINGLE_CHAN   = 1,
  parameter int F2C_CHUNK_QWS = 16,
  parameter int C2F_CHUNK_QWS = 16,
  parameter int TIMER_WIDTH   = 32
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [6:0]  cpuChan_in,
  input  logic [31:0] cpuWrData_in,
  input  logic        cpuWrValid_in,
  input  logic        cpuRdReq_in,
  output logic [31:0] cpuRdData_out,
  output logic        cpuRdValid_out,
  output logic [63:0] f2cData_out,
  output logic        f2cValid_out,
  input  logic        f2cReady_in,
  input  logic [63:0] c2fData_in,
  input  logic        c2fValid_in,
  output logic        busy_out
);

  localparam int BEAT_W = (F2C_CHUNK_QWS > 1) ? $clog2(F2C_CHUNK_QWS) : 1;
  localparam int C2F_W  = $clog2(C2F_CHUNK_QWS + 1);
  localparam int RESP_W = $clog2(2 * C2F_CHUNK_QWS + 1);

  localparam logic [6:0]        TIMER_CH    = 7'(TIMER_CHAN);
  localparam logic [6:0]        SINGLE_CH   = 7'(SINGLE_CHAN);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(F2C_CHUNK_QWS - 1);
  localparam logic [C2F_W-1:0]  C2F_TARGET  = C2F_W'(C2F_CHUNK_QWS);
  localparam logic [RESP_W-1:0] RESP_TARGET = RESP_W'(2 * C2F_CHUNK_QWS);
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = {TIMER_WIDTH{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [TIMER_WIDTH-1:0]  timer;
  logic                    single_reg;
  logic [31:0]             run_seq;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [C2F_W-1:0]        c2f_cnt;
  logic [RESP_W-1:0]       resp_cnt;

  logic                    timer_wr, single_wr, beat_xfer;
  logic [C2F_W-1:0]        c2f_sum;
  logic [RESP_W-1:0]       resp_sum;
  logic [31:0]             rd_mux;

  // Stream payload and upper write-data bits carry nothing this block uses.
  logic unused_inputs;
  assign unused_inputs = ^{c2fData_in, cpuWrData_in[31:1]};

  assign timer_wr  = cpuWrValid_in && (cpuChan_in == TIMER_CH);
  assign single_wr = cpuWrValid_in && (cpuChan_in == SINGLE_CH);
  assign beat_xfer = (state == S_SEND) && f2cReady_in;
  assign c2f_sum   = c2f_cnt + C2F_W'(c2fValid_in);
  assign resp_sum  = resp_cnt + RESP_W'(timer_wr);

  // Stream outputs decode straight from the state so reset silences them at once.
  assign f2cValid_out = (state == S_SEND);
  assign f2cData_out  = f2cValid_out ? {run_seq, 32'(beat_cnt)} : 64'd0;

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode: run start, chunk completion, and the response criteria.
  // NOTE: state_nxt is assigned before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (timer_wr) state_nxt = S_SEND;
      S_SEND:         if (beat_xfer && beat_cnt == LAST_BEAT) state_nxt = S_WAIT;
      S_WAIT: begin
        if (single_reg) begin
          if (timer_wr) state_nxt = S_DONE;
        end else if (c2f_sum == C2F_TARGET || resp_sum == RESP_TARGET) begin
          state_nxt = S_DONE;
        end
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Run datapath: timer, beat/response counters, run sequence and busy flag.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      timer      <= '0;
      single_reg <= 1'b0;
      run_seq    <= '0;
      beat_cnt   <= '0;
      c2f_cnt    <= '0;
      resp_cnt   <= '0;
      busy_out   <= 1'b0;
    end else begin
      if (single_wr) single_reg <= cpuWrData_in[0];
      unique case (state)
        S_IDLE, S_DONE: begin
          if (timer_wr) begin
            timer    <= '0;
            beat_cnt <= '0;
            c2f_cnt  <= '0;
            resp_cnt <= '0;
          end
        end
        S_SEND: begin
          if (timer != TIMER_MAX) timer <= timer + TIMER_WIDTH'(1);
          if (beat_xfer) beat_cnt <= beat_cnt + BEAT_W'(1);
        end
        S_WAIT: begin
          if (timer != TIMER_MAX) timer <= timer + TIMER_WIDTH'(1);
          if (!single_reg) begin
            c2f_cnt  <= c2f_sum;
            resp_cnt <= resp_sum;
          end
        end
        default: ;
      endcase
      if (state == S_WAIT && state_nxt == S_DONE) run_seq <= run_seq + 32'd1;
      busy_out <= (state_nxt == S_SEND) || (state_nxt == S_WAIT);
    end
  end

  // Read mux: value captured at request time, so a same-cycle write is not seen.
  always_comb begin
    rd_mux = 32'd0;
    if (cpuChan_in == TIMER_CH)       rd_mux = 32'(timer);
    else if (cpuChan_in == SINGLE_CH) rd_mux = {31'd0, single_reg};
  end

  // Read response: one-cycle valid pulse, data held at zero otherwise.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cpuRdValid_out <= 1'b0;
      cpuRdData_out  <= 32'd0;
    end else begin
      cpuRdValid_out <= cpuRdReq_in;
      cpuRdData_out  <= cpuRdReq_in ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_pcie_bench_app.sv
`timescale 1ns/1ps
// Scoreboard bench for pcie_bench_app: stimulus pushes expected beats and
// read data, a negedge monitor pops and compares whenever the DUT presents them.
module tb_pcie_bench_app;

  localparam int         F2C_QWS   = 16;
  localparam int         C2F_QWS   = 16;
  localparam logic [6:0] CH_TIMER  = 7'd0;
  localparam logic [6:0] CH_SINGLE = 7'd1;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [6:0]  cpuChan_in;
  logic [31:0] cpuWrData_in;
  logic        cpuWrValid_in, cpuRdReq_in;
  logic [31:0] cpuRdData_out;
  logic        cpuRdValid_out;
  logic [63:0] f2cData_out;
  logic        f2cValid_out, f2cReady_in;
  logic [63:0] c2fData_in;
  logic        c2fValid_in, busy_out;

  // Narrow-timer instance used only for the saturation scenario.
  logic [6:0]  s_chan;
  logic        s_wr, s_rdreq, s_rdvalid, s_f2c_valid, s_ready, s_c2f_valid, s_busy;
  logic [31:0] s_rddata;
  logic [63:0] s_f2c_data;

  pcie_bench_app dut (
    .clk_in(clk), .reset_in(reset_in), .cpuChan_in(cpuChan_in),
    .cpuWrData_in(cpuWrData_in), .cpuWrValid_in(cpuWrValid_in),
    .cpuRdReq_in(cpuRdReq_in), .cpuRdData_out(cpuRdData_out),
    .cpuRdValid_out(cpuRdValid_out), .f2cData_out(f2cData_out),
    .f2cValid_out(f2cValid_out), .f2cReady_in(f2cReady_in),
    .c2fData_in(c2fData_in), .c2fValid_in(c2fValid_in), .busy_out(busy_out)
  );

  pcie_bench_app #(.TIMER_WIDTH(4)) dut_sat (
    .clk_in(clk), .reset_in(reset_in), .cpuChan_in(s_chan),
    .cpuWrData_in(32'd0), .cpuWrValid_in(s_wr),
    .cpuRdReq_in(s_rdreq), .cpuRdData_out(s_rddata),
    .cpuRdValid_out(s_rdvalid), .f2cData_out(s_f2c_data),
    .f2cValid_out(s_f2c_valid), .f2cReady_in(s_ready),
    .c2fData_in(64'd0), .c2fValid_in(s_c2f_valid), .busy_out(s_busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  logic [63:0] exp_beats[$];
  logic [31:0] exp_rd[$];

  // Reference model of one run, in terms of cycles and event counts.
  longint      m_timer;
  int unsigned m_seq;
  bit          m_single;
  int          c2f_n, wr_n;
  bit          run_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] timer_val(input longint cycles, input int width);
    longint lim;
    lim = (longint'(1) << width) - 1;
    return 32'((cycles > lim) ? lim : cycles);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [6:0] ch);
    cpuChan_in  = ch;
    cpuRdReq_in = 1'b1;
    if (ch == CH_TIMER)       exp_rd.push_back(timer_val(m_timer, 32));
    else if (ch == CH_SINGLE) exp_rd.push_back({31'd0, m_single});
    else                      exp_rd.push_back(32'd0);
    tick();
    cpuRdReq_in = 1'b0;
  endtask

  task automatic start_run();
    cpuChan_in    = CH_TIMER;
    cpuWrData_in  = $urandom;
    cpuWrValid_in = 1'b1;
    tick();
    cpuWrValid_in = 1'b0;
    m_timer = 0; c2f_n = 0; wr_n = 0; run_done = 1'b0;
    for (int i = 0; i < F2C_QWS; i++) exp_beats.push_back({m_seq, 32'(i)});
    check("busy_after_start", {63'd0, busy_out}, 64'd1);
  endtask

  // mode 0: always ready, 1: toggling ready, 2: random ready.
  task automatic send_phase(input int mode, input bit noise, input bit inject_wr);
    int beats, k;
    beats = 0; k = 0;
    while (beats < F2C_QWS && k < 2000) begin
      case (mode)
        0:       f2cReady_in = 1'b1;
        1:       f2cReady_in = (k % 2 == 0);
        default: f2cReady_in = 1'($urandom_range(0, 1));
      endcase
      c2fValid_in   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      c2fData_in    = {$urandom, $urandom};
      cpuChan_in    = CH_TIMER;
      cpuWrValid_in = inject_wr && (k == 3);
      check("f2c_valid_in_send", {63'd0, f2cValid_out}, 64'd1);
      tick();
      m_timer++;
      if (f2cReady_in) beats++;
      k++;
    end
    f2cReady_in = 1'b0; c2fValid_in = 1'b0; cpuWrValid_in = 1'b0;
  endtask

  task automatic wait_step(input bit c2f, input bit wr, input bit rd_req);
    c2fValid_in   = c2f;
    c2fData_in    = {$urandom, $urandom};
    cpuChan_in    = CH_TIMER;
    cpuWrValid_in = wr;
    cpuRdReq_in   = rd_req;
    if (rd_req) exp_rd.push_back(timer_val(m_timer, 32));
    tick();
    c2fValid_in = 1'b0; cpuWrValid_in = 1'b0; cpuRdReq_in = 1'b0;
    m_timer++;
    c2f_n += int'(c2f);
    wr_n  += int'(wr);
    run_done = m_single ? wr : (c2f_n >= C2F_QWS || wr_n >= 2 * C2F_QWS);
    if (run_done) m_seq++;
  endtask

  task automatic wait_phase(input int p_c2f, input int p_wr, input int p_rd);
    for (int k = 0; k < 2000 && !run_done; k++)
      wait_step(($urandom % 100) < p_c2f, ($urandom % 100) < p_wr, ($urandom % 100) < p_rd);
    check("busy_after_done", {63'd0, busy_out}, 64'd0);
  endtask

  // Monitor: compares whatever the DUT presents against the queue heads.
  always @(negedge clk) begin
    if (!reset_in) begin
      if (f2cValid_out) begin
        if (exp_beats.size() == 0) check("f2c_unexpected_valid", {63'd0, f2cValid_out}, 64'd0);
        else begin
          check("f2c_data", f2cData_out, exp_beats[0]);
          if (f2cReady_in) void'(exp_beats.pop_front());
        end
      end
      if (cpuRdValid_out) begin
        if (exp_rd.size() == 0) check("rd_unexpected_valid", {63'd0, cpuRdValid_out}, 64'd0);
        else check("rd_data", {32'd0, cpuRdData_out}, {32'd0, exp_rd.pop_front()});
      end else begin
        check("rd_data_idle", {32'd0, cpuRdData_out}, 64'd0);
      end
    end
  end

  initial begin
    reset_in = 1'b1;
    cpuChan_in = '0; cpuWrData_in = '0; cpuWrValid_in = 1'b0; cpuRdReq_in = 1'b0;
    f2cReady_in = 1'b0; c2fData_in = '0; c2fValid_in = 1'b0;
    s_chan = '0; s_wr = 1'b0; s_rdreq = 1'b0; s_ready = 1'b0; s_c2f_valid = 1'b0;
    m_timer = 0; m_seq = 0; m_single = 1'b0; c2f_n = 0; wr_n = 0; run_done = 1'b0;
    tick(); tick();
    check("rst_busy",     {63'd0, busy_out}, 64'd0);
    check("rst_f2c_vld",  {63'd0, f2cValid_out}, 64'd0);
    check("rst_f2c_data", f2cData_out, 64'd0);
    check("rst_rd_vld",   {63'd0, cpuRdValid_out}, 64'd0);
    reset_in = 1'b0;
    tick();
    rd(CH_TIMER); rd(CH_SINGLE); rd(7'd5);

    // Streaming response: full-rate chunk, then 16 C2F beats at random spacing.
    start_run();
    send_phase(0, 1'b0, 1'b0);
    wait_phase(60, 0, 0);
    rd(CH_TIMER); rd(CH_TIMER); rd(CH_TIMER);

    // Register-mode response: 31 writes keep the run open, the 32nd closes it.
    start_run();
    send_phase(0, 1'b0, 1'b0);
    for (int i = 0; i < 2 * C2F_QWS - 1; i++) wait_step(1'b0, 1'b1, 1'b0);
    check("busy_after_31_writes", {63'd0, busy_out}, 64'd1);
    wait_step(1'b0, 1'b0, 1'b1);
    wait_step(1'b0, 1'b1, 1'b0);
    check("busy_after_32_writes", {63'd0, busy_out}, 64'd0);
    rd(CH_TIMER);

    // Mixed random response with C2F noise during SEND and live timer reads.
    start_run();
    send_phase(2, 1'b1, 1'b0);
    wait_phase(40, 40, 15);
    rd(CH_TIMER);

    // Backpressure: ready toggles every cycle, stalled data must hold.
    start_run();
    send_phase(1, 1'b1, 1'b0);
    wait_phase(30, 10, 10);
    rd(CH_TIMER);

    // Same-cycle read and write of SINGLE returns the old value.
    cpuChan_in = CH_SINGLE; cpuWrData_in = 32'hFFFF_FFF1;
    cpuWrValid_in = 1'b1; cpuRdReq_in = 1'b1;
    exp_rd.push_back({31'd0, m_single});
    tick();
    cpuWrValid_in = 1'b0; cpuRdReq_in = 1'b0;
    m_single = 1'b1;
    rd(CH_SINGLE);

    // Single-register mode: timer write in SEND ignored, C2F beats ignored in WAIT.
    start_run();
    send_phase(0, 1'b0, 1'b1);
    for (int i = 0; i < C2F_QWS + 4; i++) wait_step(1'b1, 1'b0, 1'b0);
    check("single_ignores_c2f", {63'd0, busy_out}, 64'd1);
    wait_phase(50, 25, 10);
    rd(CH_TIMER);

    // Reset while beat 5 is on the bus.
    start_run();
    f2cReady_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    reset_in = 1'b1;
    #1;
    check("reset_drops_valid", {63'd0, f2cValid_out}, 64'd0);
    check("reset_drops_busy",  {63'd0, busy_out}, 64'd0);
    exp_beats.delete();
    m_timer = 0; m_seq = 0; m_single = 1'b0;
    f2cReady_in = 1'b0;
    tick(); tick();
    reset_in = 1'b0;
    tick();
    rd(CH_TIMER); rd(CH_SINGLE);
    start_run();
    send_phase(0, 1'b0, 1'b0);
    wait_phase(70, 0, 0);
    rd(CH_TIMER);

    // Saturation on the 4-bit timer instance.
    s_chan = CH_TIMER; s_wr = 1'b1;
    tick();
    s_wr = 1'b0; s_ready = 1'b1;
    for (int i = 0; i < F2C_QWS; i++) tick();
    s_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_busy_in_wait", {63'd0, s_busy}, 64'd1);
    s_rdreq = 1'b1;
    tick();
    s_rdreq = 1'b0;
    check("sat_rd_valid", {63'd0, s_rdvalid}, 64'd1);
    check("sat_rd_data", {32'd0, s_rddata}, {32'd0, timer_val(F2C_QWS + 20, 4)});

    tick(); tick(); tick();
    check("beats_drained", 64'(exp_beats.size()), 64'd0);
    check("reads_drained", 64'(exp_rd.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pcie_bench_app.md
Name: pcie_bench_app

Overview:
FPGA-side responder for the PCIe round-trip latency benchmark. It sits on the application side of the TLP transceiver and answers the host benchmark sequence:
- A host write to the timer register starts a run.
- The block emits one FPGA->CPU chunk on the F2C stream.
- It times until the host's response arrives: a C2F chunk, a burst of timer-register writes, or one timer write.
- It freezes the elapsed cycle count for the host to read back.

Parameters:
TIMER_CHAN, 0, register channel of BENCHMARK_TIMER
SINGLE_CHAN, 1, register channel of SINGLE_REG_RESPONSE
F2C_CHUNK_QWS, 16, 64-bit words per emitted F2C chunk (power of two, 2..256)
C2F_CHUNK_QWS, 16, 64-bit words per C2F chunk; register-mode response is 2*C2F_CHUNK_QWS timer writes
TIMER_WIDTH, 32, width of the cycle counter (<=32)

Ports:
clk_in  in  1  application clock
reset_in  in  1  asynchronous active-high reset
cpuChan_in  in  7  register channel for the current write/read request
cpuWrData_in  in  32  register write data
cpuWrValid_in  in  1  register write strobe, one cycle per write
cpuRdReq_in  in  1  register read request, one cycle per read
cpuRdData_out  out  32  register read data
cpuRdValid_out  out  1  read data valid
f2cData_out  out  64  F2C stream data
f2cValid_out  out  1  F2C data valid
f2cReady_in  in  1  F2C sink ready
c2fData_in  in  64  C2F stream data (contents ignored)
c2fValid_in  in  1  C2F beat valid (always accepted)
busy_out  out  1  high in SEND or WAIT

Behaviour:
- Reset: state IDLE; timer=0; singleReg=0; runSeq=0; all outputs 0. Reset is async in all states; an in-flight chunk is abandoned with no further beats.
- States: IDLE, SEND, WAIT, DONE.
- Write to SINGLE_CHAN, any state: singleReg <= wrData[0].
- Write to TIMER_CHAN in IDLE or DONE:
  - timer <= 0, beatCnt <= 0, respCnt <= 0.
  - Next cycle: enter SEND.
  - The write data value is ignored.
- SEND:
  - f2cValid_out=1 and f2cData_out={runSeq[31:0], 32'(beatCnt)}.
  - A beat transfers when f2cValid_out & f2cReady_in; beatCnt then increments.
  - After beat F2C_CHUNK_QWS-1 transfers, go to WAIT on the next cycle.
  - Timer writes in SEND are ignored. C2F beats in SEND are dropped and not counted.
- WAIT, singleReg=1: the first TIMER_CHAN write -> DONE.
- WAIT, singleReg=0:
  - Each c2fValid_in beat increments c2fCnt.
  - Each TIMER_CHAN write increments respCnt.
  - A C2F beat and a timer write in the same cycle both count.
  - Go to DONE the cycle after c2fCnt reaches C2F_CHUNK_QWS or respCnt reaches 2*C2F_CHUNK_QWS.
- Timer:
  - Increments every cycle in SEND and WAIT, including the cycle DONE is decided.
  - Saturates at all-ones.
  - Frozen in IDLE and DONE.
- On entering DONE: runSeq increments, wrapping at 2^32.
- Reads:
  - cpuRdValid_out is asserted exactly one cycle after cpuRdReq_in, for one cycle.
  - cpuRdData_out holds the value sampled at request time:
    - TIMER_CHAN -> zero-extended timer.
    - SINGLE_CHAN -> {31'b0, singleReg}.
    - Any other channel -> 0.
  - A read in WAIT returns the live timer.
- cpuRdData_out returns to 0 when cpuRdValid_out is low.
- Simultaneous read and write to the same channel: the read returns the pre-write value.
- busy_out is registered from the state.

Test Plan:
- Reset, singleReg=0; TIMER write; f2cReady_in=1 throughout -> 16 beats 0x00000000_00000000..0x00000000_0000000F on consecutive cycles. Then feed 16 C2F beats -> DONE; the timer read equals the cycles from SEND entry to DONE decision, and stays constant across two further reads.
- Register mode: 32 TIMER writes in WAIT -> DONE after the 32nd. 31 writes -> still WAIT and busy_out=1.
- SINGLE_CHAN write 1, then run -> one TIMER write in WAIT ends the run. A TIMER write during SEND is ignored and the chunk still emits 16 beats.
- Backpressure: toggle f2cReady_in 1/0 each cycle -> 16 beats, data unchanged while stalled, and the timer keeps counting across stalls. The second run's beats carry runSeq=1 in the upper 32 bits.
- Saturation, with TIMER_WIDTH=4: keep the block in WAIT for 20 cycles -> the read returns 0x0000000F.
- Assert reset_in mid-SEND at beat 5 -> f2cValid_out=0 in the same cycle, state IDLE, timer read returns 0, singleReg read returns 0.
